machine_ctl: RTL

- Instruction-cycle controller for the simple RISC CPU.
- Sequences a fixed 8-clock fetch/execute cycle.
- Drives load_ir into the instruction register (two-byte fetch, high byte first) and consumes the 3-bit opcode that register produces.
- Also drives PC increment/load, accumulator load, memory rd/wr, data-bus output enable and halt.

---
 rtl/machine_ctl_if.sv | 27 ++
 rtl/machine_ctl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/machine_ctl_if.sv
// Control bundle between the instruction-cycle controller and the rest of
// the CPU: run enable and decode inputs in, datapath strobes out.
interface machine_ctl_if;
   logic       ena;
   logic [2:0] opcode;
   logic       zero;
   logic       load_ir;
   logic       inc_pc;
   logic       load_pc;
   logic       load_acc;
   logic       rd;
   logic       wr;
   logic       datactl_ena;
   logic       halt;

   // Controller side
   modport master (
      input  ena, opcode, zero,
      output load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt
   );

   // CPU datapath side
   modport slave (
      output ena, opcode, zero,
      input  load_ir, inc_pc, load_pc, load_acc, rd, wr, datactl_ena, halt
   );
endinterface

// File: rtl/machine_ctl.sv
// Instruction-cycle controller: a fixed 8-step fetch/execute sequence whose
// decoded strobes are registered, so step Sn's strobes appear the clock
// after the edge at which the step counter held Sn.
module machine_ctl #(
   parameter bit HLT_STICKY = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   machine_ctl_if.master   bus
);
   localparam logic [2:0] OP_HLT  = 3'b000;
   localparam logic [2:0] OP_SKZ  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_ANDD = 3'b011;
   localparam logic [2:0] OP_XORR = 3'b100;
   localparam logic [2:0] OP_LDA  = 3'b101;
   localparam logic [2:0] OP_STO  = 3'b110;
   localparam logic [2:0] OP_JMP  = 3'b111;

   typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} step_t;

   step_t cnt;
   logic  halted;

   logic load_ir_reg, inc_pc_reg, load_pc_reg, load_acc_reg;
   logic rd_reg, wr_reg, datactl_ena_reg, halt_reg;

   logic load_ir_next, inc_pc_next, load_pc_next, load_acc_next;
   logic rd_next, wr_next, datactl_ena_next, halt_next;

   logic alu_op;
   assign alu_op = (bus.opcode == OP_ADD) || (bus.opcode == OP_ANDD) ||
                   (bus.opcode == OP_XORR) || (bus.opcode == OP_LDA);

   // Decode of the current step and opcode into the strobes for next clock
   always_comb begin
      load_ir_next     = 1'b0;
      inc_pc_next      = 1'b0;
      load_pc_next     = 1'b0;
      load_acc_next    = 1'b0;
      rd_next          = 1'b0;
      wr_next          = 1'b0;
      datactl_ena_next = 1'b0;
      halt_next        = 1'b0;
      case (cnt)
         S0, S1: begin
            load_ir_next = 1'b1;
            rd_next      = 1'b1;
            inc_pc_next  = 1'b1;
         end
         S3: begin
            halt_next = (bus.opcode == OP_HLT);
         end
         S4: begin
            rd_next          = alu_op;
            load_pc_next     = (bus.opcode == OP_JMP);
            datactl_ena_next = (bus.opcode == OP_STO);
         end
         S5: begin
            rd_next          = alu_op;
            load_acc_next    = alu_op;
            inc_pc_next      = ((bus.opcode == OP_SKZ) && bus.zero) ||
                               (bus.opcode == OP_JMP);
            load_pc_next     = (bus.opcode == OP_JMP);
            wr_next          = (bus.opcode == OP_STO);
            datactl_ena_next = (bus.opcode == OP_STO);
         end
         S6: begin
            rd_next          = alu_op;
            datactl_ena_next = (bus.opcode == OP_STO);
         end
         S7: begin
            inc_pc_next = (bus.opcode == OP_SKZ) && bus.zero;
         end
         default: ;
      endcase
   end

   // Step sequencing, halt parking and registered strobe outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt             <= S0;
         halted          <= 1'b0;
         load_ir_reg     <= 1'b0;
         inc_pc_reg      <= 1'b0;
         load_pc_reg     <= 1'b0;
         load_acc_reg    <= 1'b0;
         rd_reg          <= 1'b0;
         wr_reg          <= 1'b0;
         datactl_ena_reg <= 1'b0;
         halt_reg        <= 1'b0;
      end else if (halted) begin
         // Parked: only reset leaves this state, ena merely re-arms S0
         if (!bus.ena) cnt <= S0;
         load_ir_reg     <= 1'b0;
         inc_pc_reg      <= 1'b0;
         load_pc_reg     <= 1'b0;
         load_acc_reg    <= 1'b0;
         rd_reg          <= 1'b0;
         wr_reg          <= 1'b0;
         datactl_ena_reg <= 1'b0;
         halt_reg        <= 1'b1;
      end else if (!bus.ena) begin
         cnt             <= S0;
         load_ir_reg     <= 1'b0;
         inc_pc_reg      <= 1'b0;
         load_pc_reg     <= 1'b0;
         load_acc_reg    <= 1'b0;
         rd_reg          <= 1'b0;
         wr_reg          <= 1'b0;
         datactl_ena_reg <= 1'b0;
         halt_reg        <= 1'b0;
      end else begin
         cnt             <= step_t'(cnt + 3'd1);
         load_ir_reg     <= load_ir_next;
         inc_pc_reg      <= inc_pc_next;
         load_pc_reg     <= load_pc_next;
         load_acc_reg    <= load_acc_next;
         rd_reg          <= rd_next;
         wr_reg          <= wr_next;
         datactl_ena_reg <= datactl_ena_next;
         halt_reg        <= halt_next;
         if (HLT_STICKY && halt_next) halted <= 1'b1;
      end
   end

   assign bus.load_ir     = load_ir_reg;
   assign bus.inc_pc      = inc_pc_reg;
   assign bus.load_pc     = load_pc_reg;
   assign bus.load_acc    = load_acc_reg;
   assign bus.rd          = rd_reg;
   assign bus.wr          = wr_reg;
   assign bus.datactl_ena = datactl_ena_reg;
   assign bus.halt        = halt_reg;
endmodule
